led_step_ctrl: RTL

LED_STEP_CTRL -- requirements
Module: led_step_ctrl

---
 rtl/led_step_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/led_step_ctrl.sv
// led_step_ctrl: run/pause and direction control for a stepping LED pattern.
//   Two raw buttons are synchronized and debounced. Each debounced press
//   produces a one-cycle event. A three-state FSM (IDLE/RUN/PAUSE) gates
//   a prescaler whose period is DIV_BASE * 2^(3-speed) cycles. A registered
//   single-cycle step pulse is issued after each terminal count.
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous, active-high
//   btn_run    - raw run/pause button (async, active-high)
//   btn_dir    - raw direction button (async, active-high)
//   speed[1:0] - step-rate select, 0 = slowest (8x DIV_BASE), 3 = fastest
//   step       - one-cycle advance pulse to the LED shift register
//   dir        - shift direction (0 = left-to-right, 1 = right-to-left)
//   running    - high only in RUN
//   step_count - number of steps issued, modulo 256
module led_step_ctrl #(
  parameter int unsigned DIV_BASE   = 6250000,
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_run,
  input  logic       btn_dir,
  input  logic [1:0] speed,
  output logic       step,
  output logic       dir,
  output logic       running,
  output logic [7:0] step_count
);

  localparam int unsigned PW = $clog2(8 * DIV_BASE);
  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  // Button index 0 = run, 1 = dir.
  logic [1:0]         sync1_q, sync1_d;
  logic [1:0]         sync2_q, sync2_d;
  logic [1:0]         deb_q, deb_d;
  logic [1:0]         deb_prev_q, deb_prev_d;
  logic [1:0][DW-1:0] cnt_q, cnt_d;
  logic [1:0]         press;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [PW-1:0] period_m1;
  logic          term;
  logic          step_q, step_d;
  logic          dir_q, dir_d;
  logic [7:0]    step_count_q, step_count_d;

  // Synchronizer and debounce
  always_comb begin
    sync1_d    = {btn_dir, btn_run};
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    cnt_d      = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Event on the 0->1 edge of the debounced level only.
  assign press = deb_q & ~deb_prev_q;

  always_comb begin
    period_m1 = '0;
    case (speed)
      2'd0:    period_m1 = PW'(8 * DIV_BASE - 1);
      2'd1:    period_m1 = PW'(4 * DIV_BASE - 1);
      2'd2:    period_m1 = PW'(2 * DIV_BASE - 1);
      default: period_m1 = PW'(DIV_BASE - 1);
    endcase
  end

  // ">=" makes a count already past a newly shortened period terminal at once.
  assign term = (presc_q >= period_m1);

  // FSM, prescaler, step, dir
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    step_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (press[0]) begin
          state_d = RUN;
          presc_d = '0;
        end
      end
      RUN: begin
        // The prescaler still advances on the pausing cycle, so a step due on
        // that cycle is issued and the frozen value is the advanced one.
        if (term) begin
          presc_d = '0;
          step_d  = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
        if (press[0]) state_d = PAUSE;
      end
      PAUSE: begin
        if (press[0]) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    dir_d        = dir_q ^ press[1];
    step_count_d = step_count_q + {7'b0, step_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      deb_q        <= '0;
      deb_prev_q   <= '0;
      cnt_q        <= '0;
      state_q      <= IDLE;
      presc_q      <= '0;
      step_q       <= 1'b0;
      dir_q        <= 1'b0;
      step_count_q <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      deb_q        <= deb_d;
      deb_prev_q   <= deb_prev_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      presc_q      <= presc_d;
      step_q       <= step_d;
      dir_q        <= dir_d;
      step_count_q <= step_count_d;
    end
  end

  assign step       = step_q;
  assign dir        = dir_q;
  assign running    = (state_q == RUN);
  assign step_count = step_count_q;

endmodule
